// File: rtl/drowsy_alarm_decoder_if.sv
// Purpose: bundles the detector-facing inputs and the alarm-facing outputs of the
//          drowsiness alarm decoder into one port.
// Latency: n/a (wiring only). Backpressure: none, the consumer accepts one vector per cycle.
// Ports:   done/out1 (detector vector), tick_1s (async 1 Hz level), ack (operator),
//          class_bits/class_valid/drowsy/alarm/state/sec_count (decoder results).
interface drowsy_alarm_decoder_if #(
  parameter int WIDTH = 10
);
  logic                    done;
  logic [2:0][WIDTH-1:0]   out1;
  logic                    tick_1s;
  logic                    ack;
  logic [2:0]              class_bits;
  logic                    class_valid;
  logic                    drowsy;
  logic                    alarm;
  logic [1:0]              state;
  logic [7:0]              sec_count;

  // Producer side: the detector / operator panel.
  modport master (
    output done, out1, tick_1s, ack,
    input  class_bits, class_valid, drowsy, alarm, state, sec_count
  );

  // Consumer side: the decoder itself.
  modport slave (
    input  done, out1, tick_1s, ack,
    output class_bits, class_valid, drowsy, alarm, state, sec_count
  );
endinterface

// File: rtl/drowsy_alarm_decoder.sv
// Purpose: thresholds the 3-lane ANN output into class bits, majority-votes recent
//          samples, times persistent drowsiness in seconds and latches an alarm until ack.
// Latency: done rise sampled at edge t -> class_bits t+1, drowsy t+2, state t+3.
// Backpressure: none; every done rising edge is captured, at most one per cycle.
// Ports:   Clock, Rst (async, active high), bus (slave modport of drowsy_alarm_decoder_if).
module drowsy_alarm_decoder #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] THRESH     = WIDTH'(512),
  parameter int               VOTE_N     = 5,
  parameter int               VOTE_K     = 3,
  parameter int               ALARM_SECS = 3
) (
  input  logic                  Clock,
  input  logic                  Rst,
  drowsy_alarm_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ALARM = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Capture stage
  // ---------------------------------------------------------------------------
  logic                  done_q, done_d;
  logic                  done_prev_q, done_prev_d;
  logic [2:0][WIDTH-1:0] out1_q, out1_d;
  logic [2:0]            class_bits_q, class_bits_d;
  logic                  class_valid_q, class_valid_d;
  logic                  done_rise;

  // out1 is registered alongside done so the captured vector is the one present
  // when done was first seen high, even if done drops again on the next cycle.
  assign done_rise = done_q & ~done_prev_q;

  always_comb begin
    done_d        = bus.done;
    done_prev_d   = done_q;
    out1_d        = bus.out1;
    class_bits_d  = class_bits_q;
    class_valid_d = done_rise;
    if (done_rise) begin
      for (int i = 0; i < 3; i++) begin
        class_bits_d[i] = (out1_q[i] >= THRESH);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vote window
  // ---------------------------------------------------------------------------
  logic [VOTE_N-1:0] win_q, win_d;
  logic [VOTE_N-1:0] win_shift;
  logic              drowsy_q, drowsy_d;
  logic              sample_drowsy;
  logic [3:0]        win_ones;

  // Two or more class-high lanes out of three.
  assign sample_drowsy = (class_bits_q[0] & class_bits_q[1]) |
                         (class_bits_q[0] & class_bits_q[2]) |
                         (class_bits_q[1] & class_bits_q[2]);

  // drowsy is computed from the post-shift window so it lands on the same edge
  // as the window update rather than one cycle later.
  always_comb begin
    win_shift[0] = sample_drowsy;
    for (int i = 1; i < VOTE_N; i++) begin
      win_shift[i] = win_q[i-1];
    end
    win_ones = 4'd0;
    for (int i = 0; i < VOTE_N; i++) begin
      win_ones = win_ones + {3'b000, win_shift[i]};
    end
  end

  always_comb begin
    win_d    = win_q;
    drowsy_d = drowsy_q;
    if (class_valid_q) begin
      win_d    = win_shift;
      drowsy_d = (win_ones >= 4'(VOTE_K));
    end
  end

  // ---------------------------------------------------------------------------
  // Seconds tick: 2-flop synchroniser, edge detect, registered pulse
  // ---------------------------------------------------------------------------
  logic tick_sync1_q, tick_sync1_d;
  logic tick_sync2_q, tick_sync2_d;
  logic tick_prev_q, tick_prev_d;
  logic sec_pulse_q, sec_pulse_d;

  always_comb begin
    tick_sync1_d = bus.tick_1s;
    tick_sync2_d = tick_sync1_q;
    tick_prev_d  = tick_sync2_q;
    sec_pulse_d  = tick_sync2_q & ~tick_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Persistence FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] sec_count_q, sec_count_d;
  logic [7:0] sec_inc;
  logic       alarm_q, alarm_d;

  assign sec_inc = (sec_count_q == 8'hFF) ? 8'hFF : sec_count_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    sec_count_d = sec_count_q;
    case (state_q)
      ST_IDLE: begin
        if (drowsy_q) begin
          state_d     = ST_ARMED;
          sec_count_d = 8'd0;
        end
      end
      ST_ARMED: begin
        // Losing drowsy takes priority over a coincident second pulse.
        if (!drowsy_q) begin
          state_d     = ST_IDLE;
          sec_count_d = 8'd0;
        end else if (sec_pulse_q) begin
          sec_count_d = sec_inc;
          if (sec_inc == 8'(ALARM_SECS)) begin
            state_d = ST_ALARM;
          end
        end
      end
      ST_ALARM: begin
        // Acknowledge only counts once the driver is no longer drowsy.
        if (bus.ack && !drowsy_q) begin
          state_d     = ST_IDLE;
          sec_count_d = 8'd0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sec_count_d = 8'd0;
      end
    endcase
    alarm_d = (state_d == ST_ALARM);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      done_q        <= 1'b0;
      done_prev_q   <= 1'b0;
      out1_q        <= '0;
      class_bits_q  <= 3'b000;
      class_valid_q <= 1'b0;
      win_q         <= '0;
      drowsy_q      <= 1'b0;
      tick_sync1_q  <= 1'b0;
      tick_sync2_q  <= 1'b0;
      tick_prev_q   <= 1'b0;
      sec_pulse_q   <= 1'b0;
      state_q       <= ST_IDLE;
      sec_count_q   <= 8'd0;
      alarm_q       <= 1'b0;
    end else begin
      done_q        <= done_d;
      done_prev_q   <= done_prev_d;
      out1_q        <= out1_d;
      class_bits_q  <= class_bits_d;
      class_valid_q <= class_valid_d;
      win_q         <= win_d;
      drowsy_q      <= drowsy_d;
      tick_sync1_q  <= tick_sync1_d;
      tick_sync2_q  <= tick_sync2_d;
      tick_prev_q   <= tick_prev_d;
      sec_pulse_q   <= sec_pulse_d;
      state_q       <= state_d;
      sec_count_q   <= sec_count_d;
      alarm_q       <= alarm_d;
    end
  end

  assign bus.class_bits  = class_bits_q;
  assign bus.class_valid = class_valid_q;
  assign bus.drowsy      = drowsy_q;
  assign bus.alarm       = alarm_q;
  assign bus.state       = state_q;
  assign bus.sec_count   = sec_count_q;

endmodule

// File: tb/tb_drowsy_alarm_decoder.sv
// Purpose: directed self-checking bench for drowsy_alarm_decoder.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_drowsy_alarm_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cv_cnt;
  int   alarm_cycles;
  int   snap;

  drowsy_alarm_decoder_if #(.WIDTH(10)) bus ();

  drowsy_alarm_decoder #(
    .WIDTH      (10),
    .THRESH     (10'd512),
    .VOTE_N     (5),
    .VOTE_K     (3),
    .ALARM_SECS (3)
  ) dut (
    .Clock (clk),
    .Rst   (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Running counts of class_valid pulses and alarm-high cycles.
  initial begin
    cv_cnt       = 0;
    alarm_cycles = 0;
    forever begin
      @(negedge clk);
      if (bus.class_valid === 1'b1) cv_cnt++;
      if (bus.alarm === 1'b1) alarm_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after t+1
  // (the cycle where class_valid is high).
  task automatic send_vec(input logic [9:0] l0, input logic [9:0] l1, input logic [9:0] l2);
    bus.out1[0] = l0;
    bus.out1[1] = l1;
    bus.out1[2] = l2;
    bus.done    = 1'b1;
    @(negedge clk);
    bus.done    = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_rise();
    bus.tick_1s = 1'b1;
    repeat (6) @(negedge clk);
    bus.tick_1s = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.done    = 1'b0;
    bus.out1    = '0;
    bus.tick_1s = 1'b0;
    bus.ack     = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_class_bits", 32'(bus.class_bits), 32'd0);
    chk("rst_class_valid", 32'(bus.class_valid), 32'd0);
    chk("rst_drowsy", 32'(bus.drowsy), 32'd0);
    chk("rst_alarm", 32'(bus.alarm), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_sec_count", 32'(bus.sec_count), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Threshold: 511 -> 0, 512 -> 1 (boundary), 1000 -> 1.
    bus.out1[0] = 10'd511;
    bus.out1[1] = 10'd512;
    bus.out1[2] = 10'd1000;
    bus.done    = 1'b1;
    @(negedge clk);
    chk("thr_cv_t0", 32'(bus.class_valid), 32'd0);
    bus.done = 1'b0;
    @(negedge clk);
    chk("thr_cv_t1", 32'(bus.class_valid), 32'd1);
    chk("thr_bits", 32'(bus.class_bits), 32'd6);
    @(negedge clk);
    chk("thr_cv_t2", 32'(bus.class_valid), 32'd0);
    chk("thr_bits_hold", 32'(bus.class_bits), 32'd6);
    chk("thr_drowsy_one", 32'(bus.drowsy), 32'd0);

    // Vote and arm: two more drowsy samples (three total).
    send_vec(10'd600, 10'd1023, 10'd0);
    send_vec(10'd0, 10'd700, 10'd512);
    chk("vote_drowsy_t1", 32'(bus.drowsy), 32'd0);
    @(negedge clk);
    chk("vote_drowsy_t2", 32'(bus.drowsy), 32'd1);
    chk("vote_state_t2", 32'(bus.state), 32'd0);
    @(negedge clk);
    chk("vote_state_t3", 32'(bus.state), 32'd1);
    // Two non-drowsy samples keep 3 of 5.
    send_vec(10'd0, 10'd0, 10'd0);
    send_vec(10'd511, 10'd511, 10'd1023);
    repeat (3) @(negedge clk);
    chk("vote_keep_drowsy", 32'(bus.drowsy), 32'd1);
    chk("vote_keep_state", 32'(bus.state), 32'd1);
    chk("vote_sec0", 32'(bus.sec_count), 32'd0);

    // Disarm from ARMED with sec_count = 2.
    snap = alarm_cycles;
    tick_rise();
    chk("dis_sec1", 32'(bus.sec_count), 32'd1);
    tick_rise();
    chk("dis_sec2", 32'(bus.sec_count), 32'd2);
    chk("dis_armed", 32'(bus.state), 32'd1);
    send_vec(10'd0, 10'd0, 10'd0);
    send_vec(10'd0, 10'd0, 10'd0);
    send_vec(10'd0, 10'd0, 10'd0);
    repeat (3) @(negedge clk);
    chk("dis_drowsy", 32'(bus.drowsy), 32'd0);
    chk("dis_state", 32'(bus.state), 32'd0);
    chk("dis_sec", 32'(bus.sec_count), 32'd0);
    chk("dis_alarm_cycles", 32'(alarm_cycles - snap), 32'd0);

    // Alarm after three seconds of persistent drowsiness.
    send_vec(10'd900, 10'd900, 10'd900);
    send_vec(10'd900, 10'd900, 10'd0);
    send_vec(10'd0, 10'd900, 10'd900);
    repeat (3) @(negedge clk);
    chk("alm_armed", 32'(bus.state), 32'd1);
    tick_rise();
    chk("alm_sec1", 32'(bus.sec_count), 32'd1);
    chk("alm_still_armed", 32'(bus.state), 32'd1);
    tick_rise();
    chk("alm_sec2", 32'(bus.sec_count), 32'd2);
    tick_rise();
    chk("alm_sec3", 32'(bus.sec_count), 32'd3);
    chk("alm_state", 32'(bus.state), 32'd2);
    chk("alm_alarm", 32'(bus.alarm), 32'd1);
    // ack ignored while drowsy.
    bus.ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.ack = 1'b0;
    chk("alm_ack_drowsy_state", 32'(bus.state), 32'd2);
    chk("alm_ack_drowsy_alarm", 32'(bus.alarm), 32'd1);
    send_vec(10'd0, 10'd0, 10'd0);
    send_vec(10'd0, 10'd0, 10'd0);
    send_vec(10'd0, 10'd0, 10'd0);
    repeat (3) @(negedge clk);
    chk("alm_clear_drowsy", 32'(bus.drowsy), 32'd0);
    chk("alm_hold_state", 32'(bus.state), 32'd2);
    chk("alm_hold_sec", 32'(bus.sec_count), 32'd3);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    @(negedge clk);
    chk("ack_state", 32'(bus.state), 32'd0);
    chk("ack_alarm", 32'(bus.alarm), 32'd0);
    chk("ack_sec", 32'(bus.sec_count), 32'd0);

    // Held done: exactly one capture.
    snap = cv_cnt;
    bus.out1 = '0;
    bus.done = 1'b1;
    repeat (20) @(negedge clk);
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_done_pulses", 32'(cv_cnt - snap), 32'd1);

    // Re-enter ALARM, then assert reset between clock edges.
    send_vec(10'd800, 10'd800, 10'd800);
    send_vec(10'd800, 10'd800, 10'd800);
    send_vec(10'd800, 10'd800, 10'd800);
    repeat (3) @(negedge clk);
    tick_rise();
    tick_rise();
    tick_rise();
    chk("rearm_alarm_state", 32'(bus.state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_class_bits", 32'(bus.class_bits), 32'd0);
    chk("arst_class_valid", 32'(bus.class_valid), 32'd0);
    chk("arst_drowsy", 32'(bus.drowsy), 32'd0);
    chk("arst_alarm", 32'(bus.alarm), 32'd0);
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_sec_count", 32'(bus.sec_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_state", 32'(bus.state), 32'd0);
    chk("post_rst_drowsy", 32'(bus.drowsy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drowsy_alarm_decoder.md
# drowsy_alarm_decoder

Consumer end of the detector's output interface: takes the 3-lane, 10-bit network output vector that `DrowsinessDetector1` presents on `done` and turns it into class bits (the inverse of the `getRealOut` target encoding). It then applies a sliding majority vote over recent classifications and a seconds-based persistence timer. It raises a latched `alarm` that only clears on operator acknowledge. It sits between the ANN core and the buzzer/LED driver.

## Interface
- `WIDTH`, 10: width of each network output lane.
- `THRESH`, 10'd512: a lane is class-high when its value is at or above `THRESH` (unsigned).
- `VOTE_N`, 5: depth of the vote window, in samples (1..8).
- `VOTE_K`, 3: number of drowsy samples within the window needed to assert `drowsy` (1..`VOTE_N`).
- `ALARM_SECS`, 3: number of seconds `drowsy` must persist before `alarm` asserts (1..255).
- `Clock` in 1: single system clock, rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `done` in 1: level from the detector; a 0→1 edge means `out1` is valid.
- `out1` in [2:0][WIDTH-1:0]: network output lanes. Held stable while `done` is high.
- `tick_1s` in 1: slow 1 Hz clock-like level. It is asynchronous to `Clock` and is synchronised internally.
- `ack` in 1: operator acknowledge, level, sampled each cycle.
- `class_bits` out 3: registered threshold result per lane.
- `class_valid` out 1: one-cycle pulse when `class_bits` updates.
- `drowsy` out 1: vote result.
- `alarm` out 1: high in ALARM state.
- `state` out 2: 0 = IDLE, 1 = ARMED, 2 = ALARM.
- `sec_count` out 8: seconds elapsed in ARMED, saturating at 255.

## Operation
- **Capture:** the block detects a rising edge of `done` (registered `done` is compared with its previous value). On that edge, `class_bits[i]` is set to (`out1[i]` >= `THRESH`) and `class_valid` pulses.
- **Sample:** a sample is drowsy when the popcount of `class_bits` is at least 2.
- **Vote window:** a `VOTE_N`-bit shift register shifts in each sample, one shift per `class_valid`. The window resets to all zeros. `drowsy` is registered and equals (ones in window >= `VOTE_K`).
- **Tick path:** `tick_1s` passes through a 2-flop synchroniser followed by a rising-edge detector, producing `sec_pulse`.
- **FSM:**
  - IDLE: when `drowsy`=1, go to ARMED and set `sec_count`=0.
  - ARMED: when `drowsy`=0, go to IDLE and set `sec_count`=0. Otherwise, each `sec_pulse` increments `sec_count`. When the incremented value equals `ALARM_SECS`, go to ALARM.
  - ALARM: `alarm`=1. Go to IDLE only when `ack`=1 and `drowsy`=0 in the same cycle; `sec_count` is cleared on that exit. While `drowsy`=1, `ack` is ignored. `sec_count` holds its value while in ALARM.
- `done` edges arriving back-to-back are each captured; the block accepts one vector per cycle at most.
- Unused `state` encoding 3 returns to IDLE on the next edge.

## Timing
- Reset value of every output is 0: `class_bits`, `class_valid`, `drowsy`, `alarm`, `state`=IDLE, `sec_count`. The vote window, synchroniser and edge registers also reset to 0.
- Reset is asynchronous. Outputs go to 0 immediately, with no clock edge needed, including when `Rst` asserts mid-ALARM or mid-ARMED.
- Latency chain, with `done` first sampled high at edge t:
  - `class_bits`/`class_valid` valid after edge t+1.
  - `drowsy` updates after edge t+2.
  - `state` changes after edge t+3.
- `tick_1s` rise to `sec_count` increment: 3–4 `Clock` edges (synchroniser plus edge detect plus FSM).
- Simultaneous events in ARMED:
  - `sec_pulse` together with `drowsy`=0: IDLE wins and no increment occurs.
  - `sec_pulse` reaching `ALARM_SECS` together with `drowsy`=1: go to ALARM.
- `out1[i]` == `THRESH` gives class-high. Values above 1023 cannot occur.
- `done` held high produces exactly one capture; it must fall and rise again to produce another.

## Test plan
- **Reset:** assert `Rst` mid-run with `state`=ALARM. Then all outputs are 0 asynchronously, and `state` stays IDLE after release with stimulus idle.
- **Threshold:** `out1`={511,512,1000}, lane index 0..2, with a `done` rise. Then `class_bits`=3'b110, `class_valid` is high for exactly one cycle at t+1, and the sample counts as drowsy.
- **Vote and arm:** with `VOTE_N`=5 and `VOTE_K`=3, send three drowsy vectors. Then `drowsy` rises 2 cycles after the third `done` edge and `state`=ARMED one cycle later. Two further non-drowsy vectors keep `drowsy`=1.
- **Disarm:** in ARMED with `sec_count`=2, send three non-drowsy vectors. Then `drowsy` falls, `state`=IDLE, `sec_count`=0, and `alarm` never asserts.
- **Alarm:** drowsy persists through 3 `tick_1s` rises. Then `sec_count` goes 1, 2, 3 and `alarm`=1 with `state`=2 after the third rise. `ack` with `drowsy`=1 leaves the block in ALARM. Clearing `drowsy` and then asserting `ack` gives IDLE, `alarm`=0 and `sec_count`=0.
- **Held done:** hold `done` high for 20 cycles. Then exactly one `class_valid` pulse occurs.
